// File: rtl/swt16_pkg.sv
// Shared constants and FSM state encoding for the swt16 MEM stage.
package swt16_pkg;

   localparam int IALU_WORD_WIDTH = 16;
   localparam int REG_IDX_WIDTH   = 4;
   localparam int DMEM_ADDR_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts request cycles without ack; flags expiry on the last allowed cycle.
module mem_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CW'(1);
      end
   end

   // A zero budget means the access waits forever.
   assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: one handshaked data-memory access at a time,
// upstream stall while outstanding, MEM/WB register drive.
module mem_access_ctrl
   import swt16_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic                       in_act_load,
   input  logic                       in_act_store,
   input  logic                       in_act_write_res_to_reg,
   input  logic [IALU_WORD_WIDTH-1:0] in_res,
   input  logic [IALU_WORD_WIDTH-1:0] in_store_data,
   input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
   output logic                       out_stall,
   output logic                       dmem_req,
   output logic                       dmem_we,
   output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
   output logic [IALU_WORD_WIDTH-1:0] dmem_wdata,
   input  logic [IALU_WORD_WIDTH-1:0] dmem_rdata,
   input  logic                       dmem_ack,
   output logic                       out_act_write_res_to_reg,
   output logic [IALU_WORD_WIDTH-1:0] out_res,
   output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
   output logic                       out_bus_error
);

   mem_state_t state, state_nx;

   logic                       mem_op;
   logic                       cnt_clr;
   logic                       cnt_en;
   logic                       expired;
   logic                       lat_ld;
   logic                       lat_wr;
   logic                       timed_out;
   logic [REG_IDX_WIDTH-1:0]   lat_idx;
   logic [IALU_WORD_WIDTH-1:0] lat_res;
   logic [IALU_WORD_WIDTH-1:0] cap_data;

   assign mem_op = in_valid & (in_act_load | in_act_store);

   mem_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clr),
      .enable (cnt_en),
      .expired(expired)
   );

   always_comb begin
      state_nx  = state;
      out_stall = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (mem_op) begin
               out_stall = 1'b1;
               state_nx  = REQ;
            end
         end
         REQ: begin
            out_stall = 1'b1;
            if (dmem_ack || expired) begin
               state_nx = DONE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            cnt_clr  = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            cnt_clr  = 1'b1;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state                    <= IDLE;
         dmem_req                 <= 1'b0;
         dmem_we                  <= 1'b0;
         dmem_addr                <= '0;
         dmem_wdata               <= '0;
         lat_ld                   <= 1'b0;
         lat_wr                   <= 1'b0;
         lat_idx                  <= '0;
         lat_res                  <= '0;
         cap_data                 <= '0;
         timed_out                <= 1'b0;
         out_act_write_res_to_reg <= 1'b0;
         out_res                  <= '0;
         out_res_reg_idx          <= '0;
         out_bus_error            <= 1'b0;
      end else begin
         state    <= state_nx;
         dmem_req <= (state_nx == REQ);
         unique case (state)
            IDLE: begin
               if (mem_op) begin
                  dmem_addr  <= in_res[DMEM_ADDR_WIDTH-1:0];
                  dmem_wdata <= in_store_data;
                  dmem_we    <= in_act_store;
                  // Store wins when both load and store are flagged.
                  lat_ld     <= in_act_load & ~in_act_store;
                  lat_wr     <= in_act_write_res_to_reg;
                  lat_idx    <= in_res_reg_idx;
                  lat_res    <= in_res;
                  timed_out  <= 1'b0;
                  out_act_write_res_to_reg <= 1'b0;
               end else begin
                  out_act_write_res_to_reg <= in_valid
                                            & in_act_write_res_to_reg;
                  out_res         <= in_res;
                  out_res_reg_idx <= in_res_reg_idx;
               end
            end
            REQ: begin
               out_act_write_res_to_reg <= 1'b0;
               if (dmem_ack) begin
                  cap_data <= dmem_rdata;
               end else if (expired) begin
                  cap_data      <= '0;
                  timed_out     <= 1'b1;
                  out_bus_error <= 1'b1;
               end
            end
            DONE: begin
               out_act_write_res_to_reg <= lat_ld & lat_wr & ~timed_out;
               out_res         <= lat_ld ? cap_data : lat_res;
               out_res_reg_idx <= lat_idx;
            end
            default: begin
               out_act_write_res_to_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_mem_access_ctrl;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_act_load, in_act_store, in_act_write_res_to_reg;
   logic [15:0] in_res, in_store_data;
   logic [3:0]  in_res_reg_idx;
   logic        out_stall, dmem_req, dmem_we;
   logic [11:0] dmem_addr;
   logic [15:0] dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        out_act_write_res_to_reg;
   logic [15:0] out_res;
   logic [3:0]  out_res_reg_idx;
   logic        out_bus_error;

   mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .in_valid                (in_valid),
      .in_act_load             (in_act_load),
      .in_act_store            (in_act_store),
      .in_act_write_res_to_reg (in_act_write_res_to_reg),
      .in_res                  (in_res),
      .in_store_data           (in_store_data),
      .in_res_reg_idx          (in_res_reg_idx),
      .out_stall               (out_stall),
      .dmem_req                (dmem_req),
      .dmem_we                 (dmem_we),
      .dmem_addr               (dmem_addr),
      .dmem_wdata              (dmem_wdata),
      .dmem_rdata              (dmem_rdata),
      .dmem_ack                (dmem_ack),
      .out_act_write_res_to_reg(out_act_write_res_to_reg),
      .out_res                 (out_res),
      .out_res_reg_idx         (out_res_reg_idx),
      .out_bus_error           (out_bus_error)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: one pending access described by its attributes.
   bit          m_known = 0;
   bit          m_busy, m_done, m_ld, m_wr, m_to, m_def;
   int          m_nack;
   logic [11:0] m_addr;
   logic [15:0] m_wdata, m_res, m_rd, m_ores;
   logic        m_we, m_req, m_wen, m_err;
   logic [3:0]  m_idx, m_oidx;
   logic        last_stall;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_ld = 0; m_wr = 0; m_to = 0; m_nack = 0;
      m_addr = '0; m_wdata = '0; m_we = 0; m_res = '0; m_rd = '0;
      m_idx = '0; m_req = 0; m_wen = 0; m_ores = '0; m_oidx = '0;
      m_err = 0; m_def = 1; m_known = 1;
   endtask

   task automatic step(input logic rn, input logic v, input logic ld,
                       input logic st, input logic wr,
                       input logic [15:0] res, input logic [15:0] sd,
                       input logic [3:0] idx, input logic [15:0] rd,
                       input logic ak);
      logic mop;
      @(negedge clock);
      reset = rn; in_valid = v; in_act_load = ld; in_act_store = st;
      in_act_write_res_to_reg = wr; in_res = res; in_store_data = sd;
      in_res_reg_idx = idx; dmem_rdata = rd; dmem_ack = ak;
      mop = v & (ld | st);
      #1;
      last_stall = out_stall;
      if (m_known)
         chk("out_stall", {31'd0, out_stall},
             {31'd0, m_busy ? 1'b1 : (m_done ? 1'b0 : mop)});
      @(posedge clock);
      if (!rn) begin
         model_reset();
      end else if (m_done) begin
         m_wen = m_ld & m_wr & !m_to;
         m_ores = m_ld ? m_rd : m_res;
         m_oidx = m_idx; m_def = 1; m_done = 0;
      end else if (m_busy) begin
         m_wen = 0; m_def = 0;
         if (ak) begin
            m_rd = rd; m_busy = 0; m_done = 1;
         end else begin
            m_nack++;
            if (TO != 0 && m_nack == TO) begin
               m_err = 1; m_to = 1; m_rd = '0; m_busy = 0; m_done = 1;
            end
         end
      end else if (mop) begin
         m_addr = res[11:0]; m_wdata = sd; m_we = st;
         m_ld = ld & !st; m_wr = wr; m_idx = idx; m_res = res;
         m_to = 0; m_nack = 0; m_busy = 1; m_wen = 0; m_def = 0;
      end else begin
         m_wen = v & wr; m_ores = res; m_oidx = idx; m_def = 1;
      end
      m_req = m_busy;
      #1;
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, m_req});
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, m_we});
      chk("dmem_addr", {20'd0, dmem_addr}, {20'd0, m_addr});
      chk("dmem_wdata", {16'd0, dmem_wdata}, {16'd0, m_wdata});
      chk("wb_en", {31'd0, out_act_write_res_to_reg}, {31'd0, m_wen});
      chk("bus_error", {31'd0, out_bus_error}, {31'd0, m_err});
      if (m_def) begin
         chk("out_res", {16'd0, out_res}, {16'd0, m_ores});
         chk("out_idx", {28'd0, out_res_reg_idx}, {28'd0, m_oidx});
      end
   endtask

   task automatic nop(input logic ak);
      step(1, 0, 0, 0, 0, 16'h0, 16'h0, 4'h0, 16'h0, ak);
   endtask

   task automatic rnd_step();
      step(($urandom_range(99) != 0), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
           4'($urandom), 16'($urandom), ($urandom_range(9) < 3));
   endtask

   int stalls, reqs;

   initial begin
      reset = 0; in_valid = 0; in_act_load = 0; in_act_store = 0;
      in_act_write_res_to_reg = 0; in_res = 0; in_store_data = 0;
      in_res_reg_idx = 0; dmem_rdata = 0; dmem_ack = 0;

      // Reset with random inputs, then one ALU op.
      for (int i = 0; i < 2; i++)
         step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom), 16'($urandom), 4'($urandom), 16'($urandom),
              1'($urandom));
      chk("rst_outs", {dmem_req, dmem_we, out_act_write_res_to_reg,
                       out_bus_error, dmem_addr, out_res_reg_idx}, 32'd0);
      chk("rst_res", {out_res, dmem_wdata}, 32'd0);
      step(1, 1, 0, 0, 1, 16'h1234, 16'h0, 4'd3, 16'h0, 0);
      chk("alu_res", {16'd0, out_res}, 32'h1234);
      chk("alu_idx", {28'd0, out_res_reg_idx}, 32'd3);
      chk("alu_wen", {31'd0, out_act_write_res_to_reg}, 32'd1);
      chk("alu_stall", {31'd0, out_stall}, 32'd0);

      // Load, ack in the third REQ cycle.
      stalls = 0; reqs = 0;
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 1, 0, 1, 16'h0010, 16'h0, 4'd5, 16'hBEEF, i == 3);
         stalls += int'(last_stall);
         reqs += int'(dmem_req);
         if (i == 0) begin
            chk("ld_addr", {20'd0, dmem_addr}, 32'h010);
            chk("ld_we", {31'd0, dmem_we}, 32'd0);
         end
      end
      chk("ld_stalls", stalls, 4);
      chk("ld_reqs", reqs, 3);
      chk("ld_wb", {15'd0, out_act_write_res_to_reg, out_res},
          {15'd0, 1'b1, 16'hBEEF});
      chk("ld_idx", {28'd0, out_res_reg_idx}, 32'd5);

      // Store with immediate ack.
      reqs = 0;
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 1, 0, 16'h0020, 16'h00AA, 4'd6, 16'h0, i == 1);
         reqs += int'(dmem_req);
         if (i == 0) begin
            chk("st_we", {31'd0, dmem_we}, 32'd1);
            chk("st_wdata", {16'd0, dmem_wdata}, 32'h00AA);
            chk("st_addr", {20'd0, dmem_addr}, 32'h020);
         end
      end
      chk("st_reqs", reqs, 1);
      chk("st_wb", {31'd0, out_act_write_res_to_reg}, 32'd0);

      // Load that never gets an ack.
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 1, 0, 1, 16'h0040, 16'h0, 4'd9, 16'h0, 0);
         if (i == 3) chk("to_err_early", {31'd0, out_bus_error}, 32'd0);
      end
      chk("to_err", {31'd0, out_bus_error}, 32'd1);
      step(1, 1, 1, 0, 1, 16'h0040, 16'h0, 4'd9, 16'h0, 0);
      chk("to_nowb", {31'd0, out_act_write_res_to_reg}, 32'd0);
      nop(0);
      nop(1);
      chk("to_sticky", {31'd0, out_bus_error}, 32'd1);
      chk("to_idle_req", {31'd0, dmem_req}, 32'd0);

      // Reset during the second REQ cycle.
      step(1, 1, 1, 0, 1, 16'h0050, 16'h0, 4'd2, 16'h0, 0);
      step(1, 1, 1, 0, 1, 16'h0050, 16'h0, 4'd2, 16'h0, 0);
      step(0, 1, 1, 0, 1, 16'h0050, 16'h0, 4'd2, 16'h0, 0);
      chk("rr_req", {31'd0, dmem_req}, 32'd0);
      chk("rr_outs", {out_act_write_res_to_reg, out_bus_error, out_res},
          32'd0);
      step(1, 0, 0, 0, 0, 16'h0, 16'h0, 4'd0, 16'h7777, 1);
      chk("rr_late_ack", {dmem_req, out_act_write_res_to_reg}, 32'd0);

      // Spurious acks around a load followed by an ALU op.
      reqs = 0;
      nop(1);
      step(1, 1, 1, 0, 1, 16'h0060, 16'h0, 4'd4, 16'hCAFE, 1);
      reqs += int'(dmem_req);
      step(1, 1, 1, 0, 1, 16'h0060, 16'h0, 4'd4, 16'hCAFE, 1);
      reqs += int'(dmem_req);
      step(1, 1, 1, 0, 1, 16'h0060, 16'h0, 4'd4, 16'h0, 1);
      reqs += int'(dmem_req);
      chk("b2b_ld", {11'd0, out_act_write_res_to_reg, out_res_reg_idx,
                     out_res}, {11'd0, 1'b1, 4'd4, 16'hCAFE});
      step(1, 1, 0, 0, 1, 16'h5555, 16'h0, 4'd7, 16'h0, 1);
      reqs += int'(dmem_req);
      chk("b2b_alu", {11'd0, out_act_write_res_to_reg, out_res_reg_idx,
                      out_res}, {11'd0, 1'b1, 4'd7, 16'h5555});
      nop(1);
      reqs += int'(dmem_req);
      chk("b2b_reqs", reqs, 1);
      chk("b2b_wen", {31'd0, out_act_write_res_to_reg}, 32'd0);

      for (int i = 0; i < 3000; i++) rnd_step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
